// File: rtl/pss_generator.sv
// rtl/pss_generator.sv - frequency-domain PSS symbol generator with AXI-Stream-like output
// Emits FFT_LEN bins per start request. The m-sequence is a constant table
// built at elaboration; bins are mapped so that d(0..62) sit in the upper
// (negative-frequency) bins and d(63..126) start at bin 0.
module pss_generator #(
  parameter int OUT_DW  = 32,
  parameter int FFT_LEN = 256,
  parameter int AMP     = 2 ** (OUT_DW / 2 - 2)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        N_id_2_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
  output logic              busy_o,
  output logic              error_o
);

  localparam int HW = OUT_DW / 2;
  localparam int CW = $clog2(FFT_LEN);

  localparam logic [HW-1:0] POS_AMP = HW'(AMP);
  localparam logic [HW-1:0] NEG_AMP = HW'(-AMP);

  // x(i+7) = x(i+4) ^ x(i), seeded with x(6..0) = 1110110
  function automatic logic [126:0] gen_mseq();
    logic [126:0] x;
    x      = '0;
    x[6:0] = 7'b1110110;
    for (int i = 0; i < 120; i++) begin
      x[i+7] = x[i+4] ^ x[i];
    end
    return x;
  endfunction

  localparam logic [126:0] M_SEQ = gen_mseq();

  // Bin b holds d(n) with n = (b + 63) mod FFT_LEN when n <= 126, else zero.
  // The cyclic shift stays in a narrow modular add: n <= 126 and shift <= 86,
  // so a single conditional subtract of 127 wraps it.
  function automatic logic [OUT_DW-1:0] bin_value(input logic [CW-1:0] b,
                                                 input logic [1:0]    nid);
    logic [CW-1:0]     n;
    logic [7:0]        shift;
    logic [7:0]        sum;
    logic [OUT_DW-1:0] val;
    n = b + CW'(63);
    case (nid)
      2'd1:    shift = 8'd43;
      2'd2:    shift = 8'd86;
      default: shift = 8'd0;
    endcase
    sum = {1'b0, n[6:0]} + shift;
    if (sum >= 8'd127) sum = sum - 8'd127;
    val = '0;
    if (n <= CW'(126)) val[HW-1:0] = M_SEQ[sum[6:0]] ? NEG_AMP : POS_AMP;
    return val;
  endfunction

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_q, state_n;
  logic [CW-1:0]     bin_q, bin_n;
  logic [1:0]        nid_q, nid_n;
  logic [OUT_DW-1:0] data_q, data_n;
  logic              valid_q, valid_n;
  logic              last_q, last_n;
  logic              error_q, error_n;

  // State and output registers; reset aborts any symbol in flight
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      bin_q   <= '0;
      nid_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_n;
      bin_q   <= bin_n;
      nid_q   <= nid_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      error_q <= error_n;
    end
  end

  // Next-state logic: accept/reject starts in IDLE, advance bins on handshake in EMIT
  always_comb begin
    state_n = state_q;
    bin_n   = bin_q;
    nid_n   = nid_q;
    data_n  = data_q;
    valid_n = valid_q;
    last_n  = last_q;
    error_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (N_id_2_i != 2'd3) begin
            state_n = EMIT;
            bin_n   = '0;
            nid_n   = N_id_2_i;
            data_n  = bin_value('0, N_id_2_i);
            valid_n = 1'b1;
            last_n  = 1'b0;
          end else begin
            error_n = 1'b1;
          end
        end
      end
      EMIT: begin
        if (valid_q && m_axis_out_tready) begin
          if (last_q) begin
            state_n = IDLE;
            data_n  = '0;
            valid_n = 1'b0;
            last_n  = 1'b0;
          end else begin
            bin_n  = bin_q + CW'(1);
            data_n = bin_value(bin_q + CW'(1), nid_q);
            last_n = ((bin_q + CW'(1)) == CW'(FFT_LEN - 1));
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign m_axis_out_tdata  = data_q;
  assign m_axis_out_tvalid = valid_q;
  assign m_axis_out_tlast  = last_q;
  assign busy_o            = (state_q == EMIT);
  assign error_o           = error_q;

endmodule

// File: tb/tb_pss_generator.sv
// tb/tb_pss_generator.sv - self-checking bench for pss_generator
// Reference model: m-sequence built by the recurrence, bins mapped by plain
// modular arithmetic. Stimulus mixes directed steps with $urandom backpressure.
module tb_pss_generator;

  localparam int OUT_DW  = 32;
  localparam int FFT_LEN = 256;
  localparam int AMP     = 2 ** (OUT_DW / 2 - 2);

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic              start_i = 1'b0;
  logic [1:0]        N_id_2_i = 2'd0;
  logic [OUT_DW-1:0] m_axis_out_tdata;
  logic              m_axis_out_tvalid;
  logic              m_axis_out_tready = 1'b1;
  logic              m_axis_out_tlast;
  logic              busy_o;
  logic              error_o;

  int total = 0;
  int bad   = 0;
  int xs[127];

  pss_generator #(.OUT_DW(OUT_DW), .FFT_LEN(FFT_LEN), .AMP(AMP)) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .N_id_2_i          (N_id_2_i),
    .m_axis_out_tdata  (m_axis_out_tdata),
    .m_axis_out_tvalid (m_axis_out_tvalid),
    .m_axis_out_tready (m_axis_out_tready),
    .m_axis_out_tlast  (m_axis_out_tlast),
    .busy_o            (busy_o),
    .error_o           (error_o)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_bin(input int nid, input int b);
    int n;
    int re;
    logic [15:0] re16;
    n = (b + 63) % FFT_LEN;
    if (n > 126) return 32'h0;
    re   = (1 - 2 * xs[(n + 43 * nid) % 127]) * AMP;
    re16 = 16'(re);
    return {16'h0, re16};
  endfunction

  // Emits one symbol starting at the current negedge and returns at the
  // negedge after the final handshake (the idle cycle), after checking it.
  task automatic run_symbol(input int nid, input bit rand_ready, input int poke_bin);
    int bin;
    int cycles;
    bit stalled;
    logic [31:0] pd;
    logic pl;
    logic rdy;
    bin = 0;
    cycles = 0;
    stalled = 1'b0;
    pd = '0;
    pl = 1'b0;
    start_i  = 1'b1;
    N_id_2_i = 2'(nid);
    @(negedge clk);
    start_i = 1'b0;
    while (bin < FFT_LEN && cycles < 5000) begin
      check($sformatf("bin%0d_nid%0d", bin, nid),
            {28'h0, m_axis_out_tvalid, m_axis_out_tlast, busy_o, error_o, m_axis_out_tdata},
            {28'h0, 1'b1, (bin == FFT_LEN - 1), 1'b1, 1'b0, exp_bin(nid, bin)});
      if (stalled)
        check($sformatf("stall_hold_bin%0d", bin),
              {31'h0, m_axis_out_tlast, m_axis_out_tdata}, {31'h0, pl, pd});
      pd = m_axis_out_tdata;
      pl = m_axis_out_tlast;
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_out_tready = rdy;
      start_i  = (bin == poke_bin);
      N_id_2_i = 2'($urandom_range(0, 3));
      @(negedge clk);
      cycles++;
      stalled = !rdy;
      if (rdy) bin++;
    end
    start_i = 1'b0;
    check("symbol_bins", 64'(bin), 64'(FFT_LEN));
    check("after_last_idle", {61'h0, m_axis_out_tvalid, busy_o, error_o}, 64'h0);
    m_axis_out_tready = 1'b1;
  endtask

  initial begin
    // Golden m-sequence from the recurrence
    xs[0] = 0; xs[1] = 1; xs[2] = 1; xs[3] = 0; xs[4] = 1; xs[5] = 1; xs[6] = 1;
    for (int i = 0; i < 120; i++) xs[i+7] = xs[i+4] ^ xs[i];

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs",
          {27'h0, m_axis_out_tvalid, m_axis_out_tlast, busy_o, error_o, m_axis_out_tdata}, 64'h0);
    reset_i = 1'b0;

    // Known bins for N_id_2 = 0 from hand-derived d(0..4)
    check("d0_bin193", 64'(exp_bin(0, 193)), 64'h0000_4000);
    check("d1_bin194", 64'(exp_bin(0, 194)), 64'h0000_C000);
    check("d4_bin197", 64'(exp_bin(0, 197)), 64'h0000_C000);

    // Full symbols, continuous ready
    run_symbol(0, 1'b0, -1);
    @(negedge clk);
    run_symbol(1, 1'b0, -1);
    @(negedge clk);
    run_symbol(2, 1'b0, -1);
    @(negedge clk);

    // Random backpressure with a start poked at bin 10
    run_symbol(0, 1'b1, 10);
    @(negedge clk);

    // Rejected start with N_id_2 = 3
    start_i  = 1'b1;
    N_id_2_i = 2'd3;
    @(negedge clk);
    start_i = 1'b0;
    check("err_pulse", {61'h0, error_o, m_axis_out_tvalid, busy_o}, 64'h4);
    @(negedge clk);
    check("err_one_cycle", {61'h0, error_o, m_axis_out_tvalid, busy_o}, 64'h0);

    // Reset at bin 100 aborts the symbol
    start_i  = 1'b1;
    N_id_2_i = 2'd1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 100; i++) @(negedge clk);
    check("pre_reset_bin100", {31'h0, m_axis_out_tvalid, m_axis_out_tdata}, {31'h0, 1'b1, exp_bin(1, 100)});
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("mid_reset_outputs",
          {27'h0, m_axis_out_tvalid, m_axis_out_tlast, busy_o, error_o, m_axis_out_tdata}, 64'h0);
    run_symbol(2, 1'b0, -1);

    // Back-to-back: start on the idle cycle right after tlast handshake
    run_symbol(1, 1'b1, -1);
    run_symbol(2, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pss_generator.md
PSS_GENERATOR -- requirements
Module: PSS_generator

Interface
REQ-001 Parameter OUT_DW, default 32, width of output sample {imag[OUT_DW/2-1:0], real[OUT_DW/2-1:0]}, each half signed two's complement.
REQ-002 Parameter FFT_LEN, default 256, number of bins per output symbol, power of two, at least 128.
REQ-003 Parameter AMP, default 2**(OUT_DW/2-2), magnitude of PSS subcarrier real part.
REQ-004 clk_i  input  1  clock; the block uses one clock.
REQ-005 reset_i  input  1  reset, synchronous and active-high.
REQ-006 start_i  input  1  single-cycle request to emit one PSS symbol.
REQ-007 N_id_2_i  input  2  requested N_id_2, sampled when start_i=1.
REQ-008 m_axis_out_tdata  output  OUT_DW  frequency-domain bin value.
REQ-009 m_axis_out_tvalid  output  1  bin valid.
REQ-010 m_axis_out_tready  input  1  downstream ready.
REQ-011 m_axis_out_tlast  output  1  high on bin FFT_LEN-1.
REQ-012 busy_o  output  1  high from accepted start to the final handshake.
REQ-013 error_o  output  1  one-cycle pulse for a rejected start.

Function
REQ-014 The m-sequence SHALL be x(i+7) = x(i+4) XOR x(i), with x(6..0) = 1,1,1,0,1,1,0, over i = 0..126.
REQ-015 d(n) SHALL be 1-2*x((n+43*N_id_2) mod 127) for n = 0..126.
REQ-016 Bin b SHALL carry real = d(n)*AMP and imag = 0, where n = (b+63) mod FFT_LEN and n <= 126; all other bins SHALL be 0.
- Bins 0..63 carry d(63..126).
- Bins FFT_LEN-63..FFT_LEN-1 carry d(0..62).
REQ-017 States SHALL be IDLE and EMIT.
- IDLE -> EMIT on start_i=1 with N_id_2_i<3: latch N_id_2, set bin counter to 0.
- EMIT -> IDLE on the handshake with tlast=1.
REQ-018 The first bin SHALL appear with tvalid=1 exactly one cycle after the accepting start_i edge.
REQ-019 In EMIT, tvalid SHALL stay 1 until the final handshake, with no bubbles while tready=1.
- A handshake (tvalid & tready) advances the bin counter.
- With tready=1 continuously, one symbol takes FFT_LEN cycles.
REQ-020 While tready=0, tdata and tlast SHALL hold stable.
REQ-021 start_i in EMIT SHALL be ignored: no queueing, no error_o.
REQ-022 start_i in IDLE with N_id_2_i=3 SHALL stay IDLE and pulse error_o the next cycle.
REQ-023 The cycle after the final handshake SHALL show tvalid=0 and busy_o=0.
- A start_i on that cycle is accepted, giving back-to-back symbols with one idle cycle between them.
REQ-024 A changing N_id_2_i during EMIT SHALL not affect the current symbol.
REQ-025 The m-sequence SHALL come from an elaboration-time 127-entry table.
- The cyclic shift is computed as (n+43*N_id_2) mod 127 using 7-bit modular add without wider overflow.
- No runtime LFSR stepping.
REQ-026 tlast SHALL be 1 only when the bin counter equals FFT_LEN-1.

Reset
REQ-027 While reset_i=1 at a rising edge, the next cycle SHALL show state IDLE and the following outputs all 0:
- m_axis_out_tvalid, m_axis_out_tlast, m_axis_out_tdata
- busy_o, error_o
REQ-028 Reset mid-symbol SHALL abort the symbol.
- tvalid is 0 the cycle after reset.
- The next start_i begins again at bin 0.

Verification
REQ-029 N_id_2=0, tready=1 -> 256 consecutive valid bins.
- Bin 193 real=+AMP (d0), bin 194 real=-AMP (d1), bin 195 real=-AMP, bin 196 real=+AMP, bin 197 real=-AMP.
- Bins 64..192 = 0; imag always 0; tlast only on bin 255; busy_o falls after that.
REQ-030 N_id_2=1 and N_id_2=2 -> every bin equals the golden model of REQ-015/016.
- Bin 193 of N_id_2=1 equals d(43) of N_id_2=0.
REQ-031 Random tready (50% duty) -> tdata/tlast stable during every stall.
- The 256-bin sequence is identical to the tready=1 run.
REQ-032 start_i with N_id_2_i=3 in IDLE -> error_o=1 for one cycle, tvalid stays 0.
- start_i pulsed at bin 10 of an active symbol -> ignored, and the symbol completes unchanged.
REQ-033 reset_i asserted at bin 100 -> tvalid=0 next cycle.
- A subsequent start with N_id_2=2 emits a full correct symbol from bin 0.
REQ-034 start_i on the cycle after tlast handshake -> second symbol starts, one idle cycle gap, correct content.
